// File: rtl/ahb_uart_tx_pkg.sv
// Shared definitions for the AHB UART transmitter:
// register offsets, STATUS/CTRL bit positions and FSM states.
package ahb_uart_tx_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_LVL   = 8;

  localparam int CT_EN = 0;
  localparam int CT_IE = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/ahb_uart_tx_fifo.sv
// Byte FIFO with first-word fall-through output.
// Ports: clk_i/rst_i, push_i/din_i, pop_i/dout_o, full_o, empty_o, level_o.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [LW-1:0] lvl_q;
  logic          do_pop;
  logic          do_push;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == LW'(DEPTH));
  assign level_o = lvl_q;
  assign dout_o  = mem_q[rp_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a byte when one leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/ahb_uart_tx.sv
// AHB-Lite slave: TX FIFO feeding an 8N1 UART with baud divider,
// STATUS/CTRL registers and level IRQ. Ports: AHB slave, o_tx, o_irq.
module ahb_uart_tx
  import ahb_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          dp_vld_q;
  logic          dp_wr_q;
  logic [1:0]    dp_addr_q;
  logic [15:0]   baud_q;
  logic [1:0]    ctrl_q;
  logic          ovf_q;
  state_t        state_q;
  logic [15:0]   cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q;
  logic          tx_q;
  logic          irq_q;

  logic          wr_en;
  logic          rd_en;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    dout;
  logic [LW-1:0] level;
  logic          busy;
  logic          go;
  logic [15:0]   bm1;
  logic          unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign o_tx      = tx_q;
  assign o_irq     = irq_q;

  assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0],
                       HWDATA[31:16]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dp_vld_q  <= 1'b0;
      dp_wr_q   <= 1'b0;
      dp_addr_q <= 2'd0;
    end else begin
      dp_vld_q  <= HSEL & HREADY & HTRANS[1];
      dp_wr_q   <= HWRITE;
      dp_addr_q <= HADDR[3:2];
    end
  end

  assign wr_en = dp_vld_q & dp_wr_q;
  assign rd_en = dp_vld_q & ~dp_wr_q;
  assign push  = wr_en & (dp_addr_q == ADDR_DATA);
  assign busy  = (state_q != IDLE);
  assign go    = ctrl_q[CT_EN] & ~empty;
  assign bm1   = baud_q - 16'd1;

  // Pop whenever the FSM starts a frame: from IDLE, or at the
  // last cycle of a stop bit for back-to-back frames.
  assign pop = go & ((state_q == IDLE) |
                     ((state_q == STOP) & (cnt_q == '0)));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (HWDATA[7:0]),
    .dout_o  (dout),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      baud_q <= DEFAULT_DIV;
      ctrl_q <= 2'b00;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en & (dp_addr_q == ADDR_BAUD)) begin
        // Divisors below 2 cannot form a bit; clamp to 2.
        baud_q <= (HWDATA[15:1] == '0) ? 16'd2 : HWDATA[15:0];
      end
      if (wr_en & (dp_addr_q == ADDR_CTRL)) begin
        ctrl_q <= HWDATA[1:0];
      end
      if (wr_en & (dp_addr_q == ADDR_STATUS) & HWDATA[ST_OVF]) begin
        ovf_q <= 1'b0;
      end else if (push & full & ~pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      unique case (dp_addr_q)
        ADDR_STATUS: begin
          HRDATA[ST_BUSY]        = busy;
          HRDATA[ST_FULL]        = full;
          HRDATA[ST_EMPTY]       = empty;
          HRDATA[ST_OVF]         = ovf_q;
          HRDATA[ST_LVL+:7]      = 7'(level);
        end
        ADDR_BAUD: HRDATA[15:0] = baud_q;
        ADDR_CTRL: HRDATA[1:0]  = ctrl_q;
        default:   HRDATA       = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= ctrl_q[CT_IE] & empty & ~busy;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= START;
            sh_q    <= dout;
            cnt_q   <= bm1;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            state_q <= DATA;
            idx_q   <= '0;
            cnt_q   <= bm1;
            tx_q    <= sh_q[0];
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= bm1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= sh_q[idx_q+3'd1];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            if (pop) begin
              state_q <= START;
              sh_q    <= dout;
              cnt_q   <= bm1;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_uart_tx.sv
// Randomized self-checking bench for ahb_uart_tx against a
// queue-based model of the FIFO and the 8N1 line waveform.
module tb_ahb_uart_tx;

  localparam int DEPTH = 8;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [31:0] HWDATA = '0;
  logic        HREADY = 1'b1;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        o_tx;
  logic        o_irq;

  ahb_uart_tx #(
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .o_tx      (o_tx),
    .o_irq     (o_irq)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic       ovf_m;
  logic [1:0] ctrl_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = 32'h4000_0000 | 32'(a);
    cyc();
    bus_idle();
    HWDATA = d;
    cyc();
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = 32'h4000_0000 | 32'(a);
    cyc();
    bus_idle();
    d = HRDATA;
    cyc();
  endtask

  task automatic do_reset();
    bus_idle();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    q.delete();
    ovf_m  = 1'b0;
    ctrl_m = 2'b00;
  endtask

  function automatic logic [31:0] exp_status(input logic busy);
    int n;
    n = q.size();
    return {17'b0, 7'(n), 4'b0, ovf_m, (n == 0), (n == DEPTH), busy};
  endfunction

  // Called in the cycle after the write that starts transmission.
  // Holds a STATUS read on the bus so busy is visible every cycle.
  task automatic run_frames(input int div, input int nb);
    logic bits[$];
    logic [7:0] b;
    chk("tx_before_start", 32'(o_tx), 32'd1);
    for (int f = 0; f < nb; f++) begin
      b = q.pop_front();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      bits.push_back(1'b1);
    end
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = 32'h4000_0004;
    cyc();
    for (int k = 0; k < nb * 10 * div; k++) begin
      chk("tx_bit", 32'(o_tx), 32'(bits[k / div]));
      chk("busy", 32'(HRDATA[0]), 32'd1);
      chk("irq_frame", 32'(o_irq), 32'd0);
      cyc();
    end
    chk("tx_after", 32'(o_tx), 32'd1);
    chk("busy_after", 32'(HRDATA[0]), 32'd0);
    chk("irq_after", 32'(o_irq), 32'd0);
    bus_idle();
    cyc();
    chk("irq_rise", 32'(o_irq), 32'(ctrl_m[1] & (q.size() == 0)));
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int          div;
    int          n;
    logic [31:0] v;

    do_reset();
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_irq", 32'(o_irq), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    rd(4'h4, r); chk("rst_status", r, 32'h4);
    rd(4'h8, r); chk("rst_baud", r, 32'd434);
    rd(4'hC, r); chk("rst_ctrl", r, 32'd0);
    rd(4'h0, r); chk("data_read", r, 32'd0);

    for (int it = 0; it < 4; it++) begin
      div = (it == 0) ? 4 : $urandom_range(2, 5);
      b   = (it == 0) ? 8'h55 : 8'($urandom);
      wr(4'h8, 32'(div));
      wr(4'hC, 32'h1);
      ctrl_m = 2'b01;
      q.push_back(b);
      wr(4'h0, {24'($urandom), b});
      run_frames(div, 1);
    end

    wr(4'hC, 32'h0);
    ctrl_m = 2'b00;
    n = DEPTH + $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (q.size() < DEPTH) q.push_back(b);
      else ovf_m = 1'b1;
      wr(4'h0, {24'h0, b});
      if (i == 2) begin
        rd(4'h4, r); chk("status_partial", r, exp_status(1'b0));
      end
    end
    rd(4'h4, r); chk("status_full_ovf", r, exp_status(1'b0));
    wr(4'h4, 32'h0);
    rd(4'h4, r); chk("status_noclr", r, exp_status(1'b0));
    wr(4'h4, 32'h8);
    ovf_m = 1'b0;
    rd(4'h4, r); chk("status_ovf_clr", r, exp_status(1'b0));
    wr(4'hC, 32'h1);
    ctrl_m = 2'b01;
    run_frames(div, DEPTH);
    rd(4'h4, r); chk("status_drained", r, exp_status(1'b0));

    do_reset();
    wr(4'h8, 32'd2);
    q.push_back(8'hA5);
    wr(4'h0, 32'hA5);
    q.push_back(8'h3C);
    wr(4'h0, 32'h3C);
    rd(4'h4, r); chk("status_two", r, exp_status(1'b0));
    wr(4'hC, 32'h3);
    ctrl_m = 2'b11;
    run_frames(2, 2);
    wr(4'hC, 32'h0);
    ctrl_m = 2'b00;

    for (int i = 0; i < 3; i++) begin
      v = {$urandom_range(0, 65535) << 16} | 32'($urandom_range(0, 1));
      wr(4'h8, v);
      rd(4'h8, r); chk("baud_clamp", r, 32'd2);
      v = $urandom;
      if (v[15:1] == 15'd0) v[4] = 1'b1;
      wr(4'h8, v);
      rd(4'h8, r); chk("baud_rw", r, {16'h0, v[15:0]});
    end
    v = $urandom & 32'hFFFF_FFFE;
    wr(4'hC, v);
    rd(4'hC, r); chk("ctrl_rw", r, {30'h0, v[1:0]});
    wr(4'hC, 32'h0);

    do_reset();
    wr(4'h8, 32'd3);
    wr(4'hC, 32'h1);
    b = 8'($urandom) & 8'hF7;
    wr(4'h0, {24'h0, b});
    for (int i = 0; i < 14; i++) cyc();
    chk("bit3_low", 32'(o_tx), 32'd0);
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    q.delete();
    ovf_m  = 1'b0;
    ctrl_m = 2'b00;
    chk("midrst_tx", 32'(o_tx), 32'd1);
    chk("midrst_irq", 32'(o_irq), 32'd0);
    rd(4'h4, r); chk("midrst_status", r, 32'h4);
    rd(4'hC, r); chk("midrst_ctrl", r, 32'h0);
    rd(4'h8, r); chk("midrst_baud", r, 32'd434);
    for (int i = 0; i < 6; i++) cyc();
    chk("midrst_tx_hold", 32'(o_tx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
